// File: rtl/pipeline_mem_lsu.sv
// rtl/pipeline_mem_lsu.sv - MEM stage load/store unit with req/gnt/rvalid D-memory port and MEM/WB register
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of masking them.
module pipeline_mem_lsu #(
    parameter int ADDR_W      = 32,
    parameter int RES_SRC_W   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read_e_i,
    input  logic                 mem_write_e_i,
    input  logic [2:0]           dmem_type_e_i,
    input  logic [31:0]          alu_result_e_i,
    input  logic [31:0]          store_data_e_i,
    input  logic [31:0]          extended_imm_e_i,
    input  logic [31:0]          pc_plus4_e_i,
    input  logic                 reg_write_en_e_i,
    input  logic [4:0]           rd_idx_e_i,
    input  logic [RES_SRC_W-1:0] result_src_e_i,
    output logic                 stall_m_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [ADDR_W-1:0]    dmem_addr_o,
    output logic [3:0]           dmem_be_o,
    output logic [31:0]          dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [31:0]          dmem_rdata_i,
    output logic [31:0]          mem_read_data_m_o,
    output logic [31:0]          alu_result_m_o,
    output logic [31:0]          extended_imm_m_o,
    output logic [31:0]          pc_plus4_m_o,
    output logic                 reg_write_en_m_o,
    output logic [4:0]           rd_idx_m_o,
    output logic [RES_SRC_W-1:0] result_src_m_o,
    output logic                 bus_err_m_o,
    output logic                 misalign_m_o,
    output logic [31:0]          bypass_m_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_GNT = 2'd1;
    localparam logic [1:0] S_WAIT_RD  = 2'd2;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_is_load;
    logic [1:0]       w_size;
    logic [1:0]       w_ofs;
    logic             w_misalign;
    logic             w_access;
    logic             w_timeout;
    logic             w_stall;
    logic             w_req;
    logic             w_load_done;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_shifted;
    logic [31:0]      w_load_ext;

    assign w_is_load = mem_read_e_i;
    assign w_size    = dmem_type_e_i[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = (mem_read_e_i | mem_write_e_i) &
                        (((w_size == 2'b01) & alu_result_e_i[0]) |
                         ((w_size == 2'b10) & (alu_result_e_i[1:0] != 2'b00)));
    assign w_ofs      = alu_result_e_i[1:0];
`else
    assign w_misalign = 1'b0;
    assign w_ofs      = (w_size == 2'b10) ? 2'b00 :
                        (w_size == 2'b01) ? {alu_result_e_i[1], 1'b0} : alu_result_e_i[1:0];
`endif

    assign w_access  = (mem_read_e_i | mem_write_e_i) & ~w_misalign;
    // The timeout window covers WAIT_GNT and WAIT_RD together; the abort cycle follows the last allowed wait cycle.
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_state != S_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYC));

    // Access FSM: next state, request and stall; grant/rvalid are ignored in the abort cycle.
    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_req       = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req = w_access;
                if (w_access) begin
                    if (!dmem_gnt_i) begin
                        w_next  = S_WAIT_GNT;
                        w_stall = 1'b1;
                    end else if (w_is_load) begin
                        w_next  = S_WAIT_RD;
                        w_stall = 1'b1;
                    end
                end
            end
            S_WAIT_GNT: begin
                if (w_timeout) begin
                    w_next = S_IDLE;
                end else begin
                    w_req = 1'b1;
                    if (!dmem_gnt_i) begin
                        w_stall = 1'b1;
                    end else if (w_is_load) begin
                        w_next  = S_WAIT_RD;
                        w_stall = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_WAIT_RD: begin
                if (w_timeout) begin
                    w_next = S_IDLE;
                end else if (dmem_rvalid_i) begin
                    w_next      = S_IDLE;
                    w_load_done = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Store lane placement and load lane extraction with sign/zero extension.
    always_comb begin
        w_be      = 4'hF;
        w_wdata   = store_data_e_i;
        w_shifted = dmem_rdata_i >> {w_ofs, 3'b000};
        w_load_ext = w_shifted;
        case (w_size)
            2'b00: begin
                w_be       = 4'b0001 << w_ofs;
                w_wdata    = {4{store_data_e_i[7:0]}};
                w_load_ext = dmem_type_e_i[2] ? {24'b0, w_shifted[7:0]} :
                                                {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            2'b01: begin
                w_be       = 4'b0011 << {w_ofs[1], 1'b0};
                w_wdata    = {2{store_data_e_i[15:0]}};
                w_load_ext = dmem_type_e_i[2] ? {16'b0, w_shifted[15:0]} :
                                                {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                w_be       = 4'hF;
                w_wdata    = store_data_e_i;
                w_load_ext = w_shifted;
            end
        endcase
    end

    assign stall_m_o    = ~reset & w_stall;
    assign dmem_req_o   = ~reset & w_req;
    assign dmem_we_o    = ~reset & mem_write_e_i & ~mem_read_e_i;
    assign dmem_addr_o  = reset ? '0 : {alu_result_e_i[ADDR_W-1:2], 2'b00};
    assign dmem_be_o    = reset ? 4'h0 : w_be;
    assign dmem_wdata_o = reset ? 32'h0 : w_wdata;

    // FSM state and wait-cycle counter; the counter only runs while an access is outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_IDLE) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // MEM/WB register: capture on completion, otherwise hold and send a bubble into WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read_data_m_o <= '0;
            alu_result_m_o    <= '0;
            extended_imm_m_o  <= '0;
            pc_plus4_m_o      <= '0;
            reg_write_en_m_o  <= 1'b0;
            rd_idx_m_o        <= '0;
            result_src_m_o    <= '0;
            bus_err_m_o       <= 1'b0;
            misalign_m_o      <= 1'b0;
        end else if (!w_stall) begin
            mem_read_data_m_o <= w_load_done ? w_load_ext : 32'h0;
            alu_result_m_o    <= alu_result_e_i;
            extended_imm_m_o  <= extended_imm_e_i;
            pc_plus4_m_o      <= pc_plus4_e_i;
            reg_write_en_m_o  <= reg_write_en_e_i & ~w_timeout & ~w_misalign;
            rd_idx_m_o        <= rd_idx_e_i;
            result_src_m_o    <= result_src_e_i;
            bus_err_m_o       <= w_timeout;
            misalign_m_o      <= w_misalign;
        end else begin
            reg_write_en_m_o  <= 1'b0;
            bus_err_m_o       <= 1'b0;
            misalign_m_o      <= 1'b0;
        end
    end

    // Forwarding value chosen by the one-hot WB select.
    always_comb begin
        bypass_m_o = ({32{result_src_m_o[0]}} & alu_result_m_o)    |
                     ({32{result_src_m_o[1]}} & mem_read_data_m_o) |
                     ({32{result_src_m_o[2]}} & extended_imm_m_o)  |
                     ({32{result_src_m_o[3]}} & pc_plus4_m_o);
    end

endmodule

// File: tb/tb_pipeline_mem_lsu.sv
// tb/tb_pipeline_mem_lsu.sv - self-checking bench for pipeline_mem_lsu
module tb_pipeline_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, rwe, gnt, rvalid;
    logic [2:0]  typ;
    logic [31:0] alu, sd, imm, pc4, rdata;
    logic [4:0]  idx;
    logic [3:0]  src;
    logic        stall, req, we, rwe_m, idx_unused, bus_err, misalign;
    logic [31:0] addr, wdata, rdata_m, alu_m, imm_m, pc4_m, bypass;
    logic [3:0]  be, src_m;
    logic [4:0]  idx_m;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_mem_lsu #(.ADDR_W(32), .RES_SRC_W(4), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset),
        .mem_read_e_i(mem_read), .mem_write_e_i(mem_write), .dmem_type_e_i(typ),
        .alu_result_e_i(alu), .store_data_e_i(sd), .extended_imm_e_i(imm), .pc_plus4_e_i(pc4),
        .reg_write_en_e_i(rwe), .rd_idx_e_i(idx), .result_src_e_i(src),
        .stall_m_o(stall), .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr),
        .dmem_be_o(be), .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
        .dmem_rdata_i(rdata), .mem_read_data_m_o(rdata_m), .alu_result_m_o(alu_m),
        .extended_imm_m_o(imm_m), .pc_plus4_m_o(pc4_m), .reg_write_en_m_o(rwe_m),
        .rd_idx_m_o(idx_m), .result_src_m_o(src_m), .bus_err_m_o(bus_err),
        .misalign_m_o(misalign), .bypass_m_o(bypass)
    );

    typedef struct {
        logic        rd, wr;
        logic [2:0]  typ;
        logic [31:0] alu, sd, imm, pc4;
        logic        rwe;
        logic [4:0]  idx;
        logic [3:0]  src;
        logic        gnt;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_stall, e_rwe;
        logic [31:0] e_byp;
    } vec_t;

    vec_t vecs [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; typ = 3'b000; alu = 0; sd = 0; imm = 0; pc4 = 0;
        rwe = 0; idx = 0; src = 4'b0001; gnt = 0; rvalid = 0; rdata = 0;
    endtask

    task automatic do_load(input string name, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] rd_word, input int gnt_cyc, input int rv_cyc,
                           input logic [31:0] exp_data);
        mem_read = 1; mem_write = 0; typ = t; alu = a; rwe = 1; idx = 5'd9; src = 4'b0010;
        for (int c = 0; c <= rv_cyc; c++) begin
            gnt    = (c == gnt_cyc);
            rvalid = (c == rv_cyc);
            rdata  = (c == rv_cyc) ? rd_word : 32'hA5A5A5A5;
            @(negedge clk);
            chk({name, "_req"}, {31'b0, req}, {31'b0, c <= gnt_cyc});
            chk({name, "_stall"}, {31'b0, stall}, {31'b0, c != rv_cyc});
            tick();
            if (c < rv_cyc) chk({name, "_bubble"}, {31'b0, rwe_m}, 32'h0);
        end
        chk({name, "_data"}, rdata_m, exp_data);
        chk({name, "_rwe"}, {31'b0, rwe_m}, 32'h1);
        chk({name, "_byp"}, bypass, exp_data);
        idle_inputs();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd0, 4'b0001, 1'b1,
                    1'b1, 1'b1, 32'h104, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h104};
        vecs[1] = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h123456AB, 32'h0, 32'h0, 1'b0, 5'd0, 4'b0001, 1'b1,
                    1'b1, 1'b1, 32'h100, 4'b0010, 32'hABABABAB, 1'b0, 1'b0, 32'h101};
        vecs[2] = '{1'b0, 1'b1, 3'b001, 32'h102, 32'hCAFEBEEF, 32'h0, 32'h0, 1'b0, 5'd0, 4'b0001, 1'b1,
                    1'b1, 1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF, 1'b0, 1'b0, 32'h102};
        vecs[3] = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h0000005A, 32'h0, 32'h0, 1'b0, 5'd0, 4'b0001, 1'b1,
                    1'b1, 1'b1, 32'h100, 4'b1000, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h103};
        vecs[4] = '{1'b0, 1'b1, 3'b001, 32'h100, 32'h00001234, 32'h0, 32'h0, 1'b0, 5'd0, 4'b0001, 1'b1,
                    1'b1, 1'b1, 32'h100, 4'b0011, 32'h12341234, 1'b0, 1'b0, 32'h100};
        vecs[5] = '{1'b0, 1'b0, 3'b000, 32'h11112222, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 4'b0001, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h11112222};
        vecs[6] = '{1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 32'h12345000, 32'h0, 1'b1, 5'd6, 4'b0100, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h12345000};
        vecs[7] = '{1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 32'h0, 32'h208, 1'b1, 5'd1, 4'b1000, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h208};

        // Reset state
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_rwe_m", {31'b0, rwe_m}, 32'h0);
        chk("rst_alu_m", alu_m, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
        reset = 1'b0;
        tick();

        // Single-cycle vectors: stores granted at once and non-memory instructions
        for (int i = 0; i < 8; i++) begin
            mem_read = vecs[i].rd; mem_write = vecs[i].wr; typ = vecs[i].typ; alu = vecs[i].alu;
            sd = vecs[i].sd; imm = vecs[i].imm; pc4 = vecs[i].pc4; rwe = vecs[i].rwe;
            idx = vecs[i].idx; src = vecs[i].src; gnt = vecs[i].gnt;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_we", i), {31'b0, we}, {31'b0, vecs[i].e_we});
                chk($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
                chk($sformatf("v%0d_be", i), {28'b0, be}, {28'b0, vecs[i].e_be});
                chk($sformatf("v%0d_wdata", i), wdata, vecs[i].e_wdata);
            end
            tick();
            chk($sformatf("v%0d_rwe_m", i), {31'b0, rwe_m}, {31'b0, vecs[i].e_rwe});
            chk($sformatf("v%0d_idx_m", i), {27'b0, idx_m}, {27'b0, vecs[i].idx});
            chk($sformatf("v%0d_byp", i), bypass, vecs[i].e_byp);
            chk($sformatf("v%0d_rdata_m", i), rdata_m, 32'h0);
        end
        idle_inputs();
        tick();

        // LB with delayed grant and a gap before rvalid
        do_load("lb", 3'b000, 32'h103, 32'h80FFFFFF, 2, 4, 32'hFFFFFF80);
        // LHU then a back-to-back SB in the following cycle
        do_load("lhu", 3'b101, 32'h102, 32'h80011234, 0, 1, 32'h00008001);
        mem_write = 1; typ = 3'b000; alu = 32'h101; sd = 32'h000000AB; gnt = 1;
        @(negedge clk);
        chk("b2b_req", {31'b0, req}, 32'h1);
        chk("b2b_be", {28'b0, be}, 32'h2);
        chk("b2b_wdata", wdata, 32'hABABABAB);
        chk("b2b_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("b2b_rdata_m", rdata_m, 32'h0);
        idle_inputs();
        do_load("lh", 3'b001, 32'h100, 32'h0000F00D, 1, 2, 32'hFFFFF00D);
        do_load("lbu", 3'b100, 32'h101, 32'h00008000, 0, 1, 32'h00000080);
        do_load("lw", 3'b010, 32'h200, 32'h13579BDF, 0, 3, 32'h13579BDF);

        // Timeout abort: grant never arrives; a grant in the abort cycle is ignored
        mem_read = 1; typ = 3'b010; alu = 32'h300; rwe = 1; idx = 5'd3; src = 4'b0010;
        for (int c = 0; c <= 5; c++) begin
            gnt = (c == 5);
            @(negedge clk);
            chk($sformatf("to%0d_req", c), {31'b0, req}, {31'b0, c < 5});
            chk($sformatf("to%0d_stall", c), {31'b0, stall}, {31'b0, c < 5});
            tick();
            if (c < 5) chk($sformatf("to%0d_bus_err", c), {31'b0, bus_err}, 32'h0);
        end
        chk("to_bus_err", {31'b0, bus_err}, 32'h1);
        chk("to_rwe_m", {31'b0, rwe_m}, 32'h0);
        idle_inputs();
        @(negedge clk);
        chk("to_after_stall", {31'b0, stall}, 32'h0);
        chk("to_after_req", {31'b0, req}, 32'h0);
        tick();
        chk("to_bus_err_pulse", {31'b0, bus_err}, 32'h0);

        // Misaligned LW @0x106
        mem_read = 1; typ = 3'b010; alu = 32'h106; rwe = 1; idx = 5'd4; src = 4'b0010;
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        chk("mis_req", {31'b0, req}, 32'h0);
        chk("mis_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("mis_flag", {31'b0, misalign}, 32'h1);
        chk("mis_rwe_m", {31'b0, rwe_m}, 32'h0);
        idle_inputs();
        tick();
        chk("mis_flag_clr", {31'b0, misalign}, 32'h0);
`else
        gnt = 1;
        @(negedge clk);
        chk("mis_req", {31'b0, req}, 32'h1);
        chk("mis_addr", addr, 32'h104);
        chk("mis_be", {28'b0, be}, 32'hF);
        tick();
        gnt = 0; rvalid = 1; rdata = 32'h11223344;
        @(negedge clk);
        chk("mis_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("mis_data", rdata_m, 32'h11223344);
        chk("mis_flag", {31'b0, misalign}, 32'h0);
        chk("mis_rwe_m", {31'b0, rwe_m}, 32'h1);
        idle_inputs();
`endif

        // Reset while waiting for read data; a late rvalid afterwards is ignored
        mem_read = 1; typ = 3'b010; alu = 32'h400; rwe = 1; idx = 5'd8; src = 4'b0010; gnt = 1;
        tick();
        gnt = 0;
        reset = 1'b1;
        #1;
        chk("rst6_req", {31'b0, req}, 32'h0);
        chk("rst6_stall", {31'b0, stall}, 32'h0);
        chk("rst6_rwe_m", {31'b0, rwe_m}, 32'h0);
        chk("rst6_alu_m", alu_m, 32'h0);
        chk("rst6_byp", bypass, 32'h0);
        idle_inputs();
        tick();
        reset = 1'b0;
        rvalid = 1; rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rst6_late_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("rst6_late_data", rdata_m, 32'h0);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
